// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port among NUM_REQ go/done requesters.
// One write in flight; IDLE -> ISSUE -> WAIT -> ACK, all outputs registered.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 6,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [WIDTH-1:0]         reg_in,
  output logic                     reg_write_en,
  input  logic                     reg_done,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                          state, state_nxt;
  logic [IDW-1:0]                  rr_ptr;
  logic [IDW-1:0]                  pick;
  logic                            found;
  logic [NUM_REQ-1:0][WIDTH-1:0]   data_lane;
  logic [NUM_REQ-1:0]              done_vec;

  assign data_lane = req_data;
  assign done_vec  = NUM_REQ'(1) << grant_id;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (reg_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs follow state_nxt so each one is valid for the whole cycle of its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      reg_in       <= '0;
      reg_write_en <= 1'b0;
      req_done     <= '0;
      busy         <= 1'b0;
    end else begin
      busy         <= (state_nxt != IDLE);
      reg_write_en <= (state_nxt == ISSUE);
      req_done     <= (state_nxt == ACK) ? done_vec : '0;
      if (state == IDLE && found) begin
        grant_id <= pick;
        reg_in   <= data_lane[pick];
      end
      if (state == ACK)
        rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table of single transactions plus
// hand sequences for round-robin, data stability, stalled/spurious done and async reset.
module tb_reg_write_arbiter;
  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_done;
  logic [W-1:0]   reg_in;
  logic           reg_write_en;
  logic           reg_done;
  logic           busy;
  logic [1:0]     grant_id;

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_done(req_done), .reg_in(reg_in), .reg_write_en(reg_write_en),
    .reg_done(reg_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic model_en  = 1'b1;
  logic auto_drop = 1'b1;
  logic last_we   = 1'b0;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [1:0]     g;
    logic [W-1:0]   din;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // Advance one clock; sample at edge+1. Models a std_reg (done one cycle after
  // write_en) and requesters that drop req_valid once they see their done.
  task automatic step();
    @(posedge clk);
    #1;
    if (model_en) reg_done = last_we;
    last_we = reg_write_en;
    check("inv_we_and_done", {31'd0, reg_write_en && (|req_done)}, 0);
    check("inv_done_onehot0", {31'd0, $onehot0(req_done)}, 1);
    if (auto_drop) req_valid = req_valid & ~req_done;
  endtask

  initial begin
    logic [W-1:0] exp_d [4];
    int k;
    int t;

    tbl[0] = '{4'b0010, pack(6'h01, 6'h2A, 6'h03, 6'h04), 2'd1, 6'h2A};
    tbl[1] = '{4'b0011, pack(6'h11, 6'h12, 6'h13, 6'h14), 2'd0, 6'h11};
    tbl[2] = '{4'b1001, pack(6'h21, 6'h22, 6'h23, 6'h24), 2'd3, 6'h24};
    tbl[3] = '{4'b1000, pack(6'h31, 6'h32, 6'h33, 6'h3F), 2'd3, 6'h3F};
    tbl[4] = '{4'b0110, pack(6'h00, 6'h15, 6'h16, 6'h17), 2'd1, 6'h15};
    tbl[5] = '{4'b0100, pack(6'h05, 6'h06, 6'h3E, 6'h08), 2'd2, 6'h3E};
    tbl[6] = '{4'b0001, pack(6'h3A, 6'h0B, 6'h0C, 6'h0D), 2'd0, 6'h3A};
    tbl[7] = '{4'b0101, pack(6'h19, 6'h1A, 6'h1B, 6'h1C), 2'd2, 6'h1B};

    reset = 1'b1; req_valid = '0; req_data = '0; reg_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_we", {31'd0, reg_write_en}, 0);
    check("rst_done", {28'd0, req_done}, 0);
    check("rst_reg_in", {26'd0, reg_in}, 0);
    check("rst_grant", {30'd0, grant_id}, 0);
    reset = 1'b0;

    // Single transactions; rr_ptr carries over from one vector to the next.
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].valid;
      req_data  = tbl[i].data;
      step();
      check("tbl_we_c1", {31'd0, reg_write_en}, 1);
      check("tbl_reg_in", {26'd0, reg_in}, {26'd0, tbl[i].din});
      check("tbl_grant", {30'd0, grant_id}, {30'd0, tbl[i].g});
      check("tbl_busy_c1", {31'd0, busy}, 1);
      step();
      check("tbl_we_c2", {31'd0, reg_write_en}, 0);
      step();
      check("tbl_done_c3", {28'd0, req_done}, 32'd1 << tbl[i].g);
      req_valid = '0;
      step();
      check("tbl_idle_c4", {31'd0, busy}, 0);
      check("tbl_done_c4", {28'd0, req_done}, 0);
    end

    // Data stability and a stalled register done.
    model_en = 1'b0; reg_done = 1'b0;
    req_valid = 4'b0100;
    req_data  = pack(6'h00, 6'h00, 6'h11, 6'h00);
    step();
    check("stab_we", {31'd0, reg_write_en}, 1);
    check("stab_grant", {30'd0, grant_id}, 2);
    step();
    req_data[2*W +: W] = 6'h22;
    req_valid = req_valid | 4'b0001;
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_busy", {31'd0, busy}, 1);
      check("stall_no_done", {28'd0, req_done}, 0);
      check("stab_reg_in", {26'd0, reg_in}, 6'h11);
    end
    reg_done = 1'b1;
    step();
    reg_done = 1'b0;
    check("stall_done", {28'd0, req_done}, 4'b0100);
    check("stab_reg_in_ack", {26'd0, reg_in}, 6'h11);
    req_valid = '0;
    step();
    check("ack_to_idle", {31'd0, busy}, 0);
    reg_done = 1'b1;
    step();
    reg_done = 1'b0;
    check("spur_busy", {31'd0, busy}, 0);
    check("spur_we", {31'd0, reg_write_en}, 0);
    check("spur_done", {28'd0, req_done}, 0);

    // Async reset in WAIT; rr_ptr was 3, so without reset 3 would win again.
    req_valid = 4'b1010;
    req_data  = pack(6'h00, 6'h07, 6'h00, 6'h05);
    step();
    check("ar_grant_pre", {30'd0, grant_id}, 3);
    step();
    step();
    #1 reset = 1'b1;
    #1;
    check("ar_busy", {31'd0, busy}, 0);
    check("ar_we", {31'd0, reg_write_en}, 0);
    check("ar_done", {28'd0, req_done}, 0);
    check("ar_grant", {30'd0, grant_id}, 0);
    check("ar_reg_in", {26'd0, reg_in}, 0);
    step();
    reset = 1'b0;
    model_en = 1'b1;
    t = 0;
    while (!reg_write_en && t < 6) begin step(); t++; end
    check("ar_regrant_seen", {31'd0, reg_write_en}, 1);
    check("ar_regrant_id", {30'd0, grant_id}, 1);
    check("ar_regrant_data", {26'd0, reg_in}, 6'h07);
    t = 0;
    while (req_done == '0 && t < 6) begin step(); t++; end
    check("ar_regrant_done", {28'd0, req_done}, 4'b0010);
    req_valid = '0;
    step();

    // Round-robin with everyone held valid from a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_d = '{6'h0A, 6'h1B, 6'h2C, 6'h3D};
    req_data  = pack(exp_d[0], exp_d[1], exp_d[2], exp_d[3]);
    req_valid = 4'b1111;
    k = 0;
    for (int cyc = 1; cyc <= 40 && k < 4; cyc++) begin
      step();
      if (reg_write_en) begin
        check("rr_order", {30'd0, grant_id}, k);
        check("rr_data", {26'd0, reg_in}, {26'd0, exp_d[k]});
        check("rr_cycle", cyc, 1 + 4 * k);
        k++;
      end
    end
    check("rr_count", k, 4);
    t = 0;
    while (busy && t < 8) begin step(); t++; end
    check("rr_drained", {31'd0, busy}, 0);
    req_valid = 4'b1001;
    step();
    check("rr_wrap_we", {31'd0, reg_write_en}, 1);
    check("rr_wrap_grant", {30'd0, grant_id}, 0);
    req_valid = '0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
